seq_stage_ctrl: RTL

//  Multi-cycle sequencer for the Y86-64 SEQ processor. It steps one instruction at a time through

---
 rtl/y86_pkg.sv | 37 +++
 rtl/y86_icode_class.sv | 46 ++++
 rtl/seq_stage_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 encodings for the SEQ control path
//
// Purpose: icode values, architectural status codes and the sequencer state
//          encoding used by seq_stage_ctrl and y86_icode_class.
// Ports:   none (package).
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_PCUPD     = 3'd6,
    ST_HALTED    = 3'd7
  } seq_state_e;

endpackage

// File: rtl/y86_icode_class.sv
// rtl/y86_icode_class.sv - combinational icode classifier for the Y86-64 control path
//
// Purpose: maps an icode to its legality and which optional stages it needs.
// Ports:
//   icode_i     in  4  icode to classify
//   legal_o     out 1  icode is a defined instruction (0..B)
//   uses_mem_o  out 1  instruction performs a data-memory access
//   uses_wb_o   out 1  instruction writes the register file
module y86_icode_class
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic       legal_o,
  output logic       uses_mem_o,
  output logic       uses_wb_o
);

  always_comb begin
    legal_o    = 1'b0;
    uses_mem_o = 1'b0;
    uses_wb_o  = 1'b0;
    case (icode_i)
      ICODE_HALT, ICODE_NOP, ICODE_JXX: begin
        legal_o = 1'b1;
      end
      ICODE_RRMOVQ, ICODE_IRMOVQ, ICODE_OPQ: begin
        legal_o   = 1'b1;
        uses_wb_o = 1'b1;
      end
      ICODE_RMMOVQ: begin
        legal_o    = 1'b1;
        uses_mem_o = 1'b1;
      end
      // call/ret/push/pop touch the stack and update %rsp.
      ICODE_MRMOVQ, ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ: begin
        legal_o    = 1'b1;
        uses_mem_o = 1'b1;
        uses_wb_o  = 1'b1;
      end
      default: begin
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_stage_ctrl.sv
// rtl/seq_stage_ctrl.sv - multi-cycle stage sequencer for the Y86-64 SEQ processor
//
// Purpose: steps one instruction at a time through FETCH/DECODE/EXECUTE/
//          MEMORY/WRITEBACK/PCUPD, skipping unused stages, handshaking with
//          instruction/data memory and owning the architectural status.
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   start                 begin execution (sampled in IDLE only)
//   imem_ready/icode/instr_valid/imem_error   fetch response
//   dmem_ready/dmem_error data access response
//   imem_req, dmem_req    held high throughout FETCH / MEMORY
//   decode_en, execute_en, wb_en, pc_en        one-cycle stage pulses
//   stat, halted          status code (1 AOK,2 HLT,3 ADR,4 INS); HALTED flag
//   cycle_cnt, retired_cnt  saturating activity counters
module seq_stage_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             imem_ready,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_ready,
  input  logic             dmem_error,
  output logic             imem_req,
  output logic             decode_en,
  output logic             execute_en,
  output logic             dmem_req,
  output logic             wb_en,
  output logic             pc_en,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  import y86_pkg::*;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  seq_state_e        state_q, state_d;
  logic [3:0]        cur_icode_q, cur_icode_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [2:0]        stat_q, stat_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic [3:0] class_icode;
  logic       cls_legal;
  logic       cls_mem;
  logic       cls_wb;

  // In FETCH the incoming icode is being judged for legality; afterwards the
  // latched icode steers stage skipping.
  assign class_icode = (state_q == ST_FETCH) ? icode : cur_icode_q;

  y86_icode_class u_class (
    .icode_i    (class_icode),
    .legal_o    (cls_legal),
    .uses_mem_o (cls_mem),
    .uses_wb_o  (cls_wb)
  );

  always_comb begin
    state_d     = state_q;
    cur_icode_d = cur_icode_q;
    wait_d      = '0;
    stat_d      = stat_q;
    cycle_d     = cycle_q;
    retired_d   = retired_q;

    if ((state_q != ST_IDLE) && (state_q != ST_HALTED) && (cycle_q != '1)) begin
      cycle_d = cycle_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (imem_ready) begin
          cur_icode_d = icode;
          if (imem_error) begin
            stat_d  = STAT_ADR;
            state_d = ST_HALTED;
          end else if (!cls_legal || !instr_valid) begin
            stat_d  = STAT_INS;
            state_d = ST_HALTED;
          end else if (icode == ICODE_HALT) begin
            // halt is not retired and leaves the PC on itself.
            stat_d  = STAT_HLT;
            state_d = ST_HALTED;
          end else begin
            state_d = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (cls_mem) begin
          state_d = ST_MEMORY;
        end else if (cls_wb) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_PCUPD;
        end
      end
      ST_MEMORY: begin
        // wait_q counts cycles already spent here; it is zero on entry
        // because every other state loads zero.
        wait_d = wait_q + 1'b1;
        if (dmem_ready) begin
          if (dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = ST_HALTED;
          end else if (cls_wb) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_PCUPD;
          end
        end else if (wait_q == WAIT_LAST) begin
          stat_d  = STAT_ADR;
          state_d = ST_HALTED;
        end
      end
      ST_WRITEBACK: begin
        state_d = ST_PCUPD;
      end
      ST_PCUPD: begin
        if (retired_q != '1) begin
          retired_d = retired_q + 1'b1;
        end
        state_d = ST_FETCH;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_icode_q <= ICODE_NOP;
      wait_q      <= '0;
      stat_q      <= STAT_AOK;
      cycle_q     <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_icode_q <= cur_icode_d;
      wait_q      <= wait_d;
      stat_q      <= stat_d;
      cycle_q     <= cycle_d;
      retired_q   <= retired_d;
    end
  end

  // Moore outputs: decoded from the state register only.
  assign imem_req    = (state_q == ST_FETCH);
  assign decode_en   = (state_q == ST_DECODE);
  assign execute_en  = (state_q == ST_EXECUTE);
  assign dmem_req    = (state_q == ST_MEMORY);
  assign wb_en       = (state_q == ST_WRITEBACK);
  assign pc_en       = (state_q == ST_PCUPD);
  assign halted      = (state_q == ST_HALTED);
  assign stat        = stat_q;
  assign cycle_cnt   = cycle_q;
  assign retired_cnt = retired_q;

endmodule
